// File: rtl/bobc_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding, default widths
// and active-low 7-segment patterns (segment a in bit 0 .. g in bit 6).
package bobc_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONVERTE = 2'd1,
      FIM      = 2'd2
   } estado_t;

   localparam int W_DEF        = 16;
   localparam int NDIG_DEF     = 5;
   localparam int SCAN_DIV_DEF = 4;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg_de_digito(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/varredura_7seg.sv
// Multiplexed 7-segment scan: holds each digit SCAN_DIV cycles, digits 0..NDIG-1
// wrapping, active-low anode and segment drive. Used only with CONVERSOR_SEG7_EN.
module varredura_7seg
   import bobc_pkg::*;
#(
   parameter int NDIG     = NDIG_DEF,
   parameter int SCAN_DIV = SCAN_DIV_DEF
) (
   input  logic              ck_i,
   input  logic              rst_i,
   input  logic [4*NDIG-1:0] bcd_i,
   output logic [NDIG-1:0]   anodo_o,
   output logic [6:0]        seg_o
);

   localparam int DIGW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DIVW-1:0] div_q, div_d;
   logic [DIGW-1:0] dig_q, dig_d;
   logic [3:0]      nibble;

   always_ff @(posedge ck_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= DIVW'(SCAN_DIV - 1);
         dig_q <= '0;
      end else begin
         div_q <= div_d;
         dig_q <= dig_d;
      end
   end

   // Down-counter per digit; terminal count advances the digit index.
   always_comb begin
      div_d = div_q - DIVW'(1);
      dig_d = dig_q;
      if (div_q == '0) begin
         div_d = DIVW'(SCAN_DIV - 1);
         dig_d = (dig_q == DIGW'(NDIG - 1)) ? '0 : dig_q + DIGW'(1);
      end
   end

   always_comb begin
      nibble = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (dig_q == DIGW'(i)) nibble = bcd_i[4*i +: 4];
      end
   end

   assign anodo_o = ~(NDIG'(1) << dig_q);
   assign seg_o   = seg_de_digito(nibble);

endmodule

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Define CONVERSOR_SEG7_EN to add the multiplexed 7-segment outputs anodo/seg.
//
// state    | meaning
// OCIOSO   | idle, captures Resultado on valido
// CONVERTE | W correct-and-shift iterations
// FIM      | publish acc to bcd, pulse pronto_bcd
module conversor_bcd
   import bobc_pkg::*;
#(
   parameter int W        = W_DEF,
   parameter int NDIG     = NDIG_DEF,
   parameter int SCAN_DIV = SCAN_DIV_DEF
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              valido,
   input  logic [W-1:0]      Resultado,
   output logic              ocupado,
   output logic              pronto_bcd,
   output logic [4*NDIG-1:0] bcd
`ifdef CONVERSOR_SEG7_EN
   ,
   output logic [NDIG-1:0]   anodo,
   output logic [6:0]        seg
`endif
);

   localparam int BW = 4 * NDIG;
   localparam int CW = $clog2(W + 1);

   if ((SCAN_DIV < 1) || ((64'd10 ** NDIG) <= (64'd1 << W))) begin : g_param_invalid
      $error("conversor_bcd: NDIG too small for W, or SCAN_DIV < 1");
   end

   estado_t       estado_q, estado_d;
   logic [BW-1:0] acc_q, acc_d, acc_corr;
   logic [W-1:0]  bin_q, bin_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bcd_q, bcd_d;
   logic          pronto_q, pronto_d;

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         estado_q <= OCIOSO;
         acc_q    <= '0;
         bin_q    <= '0;
         cnt_q    <= '0;
         bcd_q    <= '0;
         pronto_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         acc_q    <= acc_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         pronto_q <= pronto_d;
      end
   end

   // Per-nibble +3 with no carry out; NDIG sizing keeps every nibble <= 9 before shift.
   always_comb begin
      acc_corr = acc_q;
      for (int i = 0; i < NDIG; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      estado_d = estado_q;
      acc_d    = acc_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      pronto_d = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (valido) begin
               bin_d    = Resultado;
               acc_d    = '0;
               cnt_d    = CW'(W);
               estado_d = CONVERTE;
            end
         end
         CONVERTE: begin
            {acc_d, bin_d} = {acc_corr[BW-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) estado_d = FIM;
         end
         FIM: begin
            bcd_d    = acc_q;
            pronto_d = 1'b1;
            estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   assign ocupado    = (estado_q != OCIOSO);
   assign pronto_bcd = pronto_q;
   assign bcd        = bcd_q;

`ifdef CONVERSOR_SEG7_EN
   varredura_7seg #(
      .NDIG     (NDIG),
      .SCAN_DIV (SCAN_DIV)
   ) u_varredura (
      .ck_i    (ck),
      .rst_i   (rst),
      .bcd_i   (bcd_q),
      .anodo_o (anodo),
      .seg_o   (seg)
   );
`endif

endmodule

// File: tb/tb_conversor_bcd.sv
// Scoreboard bench for conversor_bcd: stimulus pushes expected results with their
// due cycle, a monitor compares pronto_bcd/bcd/ocupado every cycle.
module tb_conversor_bcd;

   localparam int W    = 16;
   localparam int NDIG = 5;

   logic              ck = 1'b0;
   logic              rst = 1'b1;
   logic              valido = 1'b0;
   logic [W-1:0]      Resultado = '0;
   logic              ocupado;
   logic              pronto_bcd;
   logic [4*NDIG-1:0] bcd;
`ifdef CONVERSOR_SEG7_EN
   logic [NDIG-1:0]   anodo;
   logic [6:0]        seg;
`endif

   conversor_bcd #(.W(W), .NDIG(NDIG), .SCAN_DIV(4)) dut (
      .ck         (ck),
      .rst        (rst),
      .valido     (valido),
      .Resultado  (Resultado),
      .ocupado    (ocupado),
      .pronto_bcd (pronto_bcd),
      .bcd        (bcd)
`ifdef CONVERSOR_SEG7_EN
      ,
      .anodo      (anodo),
      .seg        (seg)
`endif
   );

   always #5 ck = ~ck;

   typedef struct {
      logic [4*NDIG-1:0] bcd;
      int                cyc;
   } exp_t;

   exp_t              sb_q[$];
   logic [4*NDIG-1:0] exp_bcd = '0;
   int                cyc = 0;
   int                busy_lo = 0;
   int                busy_hi = -1;
   int                free_edge = 0;
   int                n_chk = 0;
   int                n_fail = 0;
   bit                mon_en = 1'b0;

   always @(posedge ck) cyc++;

   function automatic logic [4*NDIG-1:0] ref_bcd(input int unsigned v);
      logic [4*NDIG-1:0] r;
      r = '0;
      for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
      return r;
   endfunction

   function automatic logic [6:0] ref_seg(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Drives one capture attempt; the model decides whether the idle FSM takes it.
   task automatic issue(input int unsigned v);
      int e;
      @(negedge ck);
      valido    = 1'b1;
      Resultado = W'(v);
      e = cyc + 1;
      if (e >= free_edge) begin
         sb_q.push_back('{bcd: ref_bcd(v), cyc: e + W + 1});
         busy_lo   = e;
         busy_hi   = e + W;
         free_edge = e + W + 2;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge ck);
         valido = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge ck);
      rst    = 1'b1;
      valido = 1'b0;
      sb_q.delete();
      exp_bcd   = '0;
      busy_hi   = -1;
      free_edge = 0;
      repeat (2) @(negedge ck);
      rst = 1'b0;
   endtask

   initial begin : monitor
      bit exp_p;
      wait (mon_en);
      forever begin
         @(negedge ck);
         #1;
         exp_p = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
         chk("pronto_bcd", 32'(pronto_bcd), 32'(exp_p));
         if (exp_p) begin
            exp_bcd = sb_q[0].bcd;
            void'(sb_q.pop_front());
         end
         chk("bcd", 32'(bcd), 32'(exp_bcd));
         chk("ocupado", 32'(ocupado), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
`ifdef CONVERSOR_SEG7_EN
         begin
            int zeros;
            int idx;
            zeros = 0;
            idx   = 0;
            for (int i = 0; i < NDIG; i++) begin
               if (anodo[i] == 1'b0) begin
                  zeros++;
                  idx = i;
               end
            end
            chk("anodo_onehot", 32'(zeros), 32'd1);
            chk("seg", 32'(seg), 32'(ref_seg(int'(exp_bcd[4*idx +: 4]))));
         end
`endif
      end
   end

   initial begin : stimulus
      repeat (3) @(negedge ck);
      rst = 1'b0;
      mon_en = 1'b1;
      idle(5);

      issue(14);           idle(W + 4);
      issue(16'hFFFF);     idle(W + 4);
      issue(0);            idle(W + 4);

      issue(9999);         idle(5);
      issue(100);          idle(W + 4);

      issue(1234);         idle(8);
      do_reset();          idle(2);
      issue(1234);         idle(W + 4);

      for (int i = 0; i < 5 * (W + 2); i++) issue($urandom_range(0, 65535));
      idle(W + 4);

      for (int i = 0; i < 30; i++) begin
         issue(($urandom_range(0, 3) == 0) ? 65535 - $urandom_range(0, 2) : $urandom_range(0, 65535));
         idle($urandom_range(0, 20));
      end

      for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge ck);
      if (sb_q.size() > 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
